sprite_line_scheduler: RTL and testbench

//  Per-scanline sprite scheduler between the object table and the font-based sprite renderer.
//  On each line_start it scans the NUM_SPRITES descriptors and selects up to MAX_ACTIVE sprites

---
 rtl/sprite_line_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the descriptor table, collects up to MAX_ACTIVE hits
// into a shadow set and commits it atomically. Optional macro SPRITE_SCHED_DROPCNT_EN adds drop_count.
module sprite_line_scheduler #(
    parameter int NUM_SPRITES = 32,
    parameter int MAX_ACTIVE  = 8,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    localparam int AW         = $clog2(NUM_SPRITES),
    localparam int DW         = 4 + X_W + Y_W
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      line_start,
    input  logic [Y_W-1:0]            next_line,
    output logic                      desc_rd,
    output logic [AW-1:0]             desc_addr,
    input  logic [DW-1:0]             desc_data,
    output logic [MAX_ACTIVE-1:0]     slot_valid,
    output logic [MAX_ACTIVE*3-1:0]   slot_type,
    output logic [MAX_ACTIVE*X_W-1:0] slot_x,
    output logic [MAX_ACTIVE*4-1:0]   slot_row,
    output logic                      busy,
    output logic                      done,
`ifdef SPRITE_SCHED_DROPCNT_EN
    output logic [7:0]                drop_count,
`endif
    output logic                      overflow
);
    localparam int CW = $clog2(MAX_ACTIVE + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_SPRITES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_COMMIT} state_t;

    function automatic logic [4:0] height(input logic [2:0] t);
        case (t)
            3'd2:                 height = 5'd14;
            3'd4, 3'd5, 3'd6:     height = 5'd9;
            default:              height = 5'd16;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [Y_W-1:0]  line_q, line_d;
    logic            eval_q, eval_d;
    logic [CW-1:0]   count_q, count_d;
    logic            sh_ovf_q, sh_ovf_d;
    logic [2:0]      sh_type_q [MAX_ACTIVE];
    logic [2:0]      sh_type_d [MAX_ACTIVE];
    logic [X_W-1:0]  sh_x_q    [MAX_ACTIVE];
    logic [X_W-1:0]  sh_x_d    [MAX_ACTIVE];
    logic [3:0]      sh_row_q  [MAX_ACTIVE];
    logic [3:0]      sh_row_d  [MAX_ACTIVE];
    logic            commit;

    logic [MAX_ACTIVE-1:0]     slot_valid_q;
    logic [MAX_ACTIVE*3-1:0]   slot_type_q;
    logic [MAX_ACTIVE*X_W-1:0] slot_x_q;
    logic [MAX_ACTIVE*4-1:0]   slot_row_q;
    logic                      overflow_q;

`ifdef SPRITE_SCHED_DROPCNT_EN
    logic [7:0] sh_drops_q, sh_drops_d;
    logic [7:0] drop_count_q;
    logic [8:0] drop_sum;
`endif

    logic            d_en;
    logic [2:0]      d_type;
    logic [X_W-1:0]  d_x;
    logic [Y_W-1:0]  d_y;
    logic [Y_W:0]    d_diff;
    logic            hit;

    assign d_en   = desc_data[DW-1];
    assign d_type = desc_data[X_W+Y_W +: 3];
    assign d_x    = desc_data[Y_W +: X_W];
    assign d_y    = desc_data[Y_W-1:0];
    // Extra MSB catches y > line as a borrow, so no wrap-around hits.
    assign d_diff = {1'b0, line_q} - {1'b0, d_y};
    assign hit    = eval_q && d_en && !d_diff[Y_W] && (d_diff < (Y_W+1)'(height(d_type)));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        line_d    = line_q;
        eval_d    = (state_q == S_SCAN) && !line_start;
        count_d   = count_q;
        sh_ovf_d  = sh_ovf_q;
        sh_type_d = sh_type_q;
        sh_x_d    = sh_x_q;
        sh_row_d  = sh_row_q;
        commit    = 1'b0;
`ifdef SPRITE_SCHED_DROPCNT_EN
        sh_drops_d = sh_drops_q;
`endif

        if (hit) begin
            if (count_q < CW'(MAX_ACTIVE)) begin
                for (int i = 0; i < MAX_ACTIVE; i++) begin
                    if (CW'(i) == count_q) begin
                        sh_type_d[i] = d_type;
                        sh_x_d[i]    = d_x;
                        sh_row_d[i]  = d_diff[3:0];
                    end
                end
                count_d = count_q + 1'b1;
            end else begin
                sh_ovf_d = 1'b1;
`ifdef SPRITE_SCHED_DROPCNT_EN
                if (sh_drops_q != 8'hFF) sh_drops_d = sh_drops_q + 8'd1;
`endif
            end
        end

        case (state_q)
            S_IDLE:   state_d = S_IDLE;
            S_SCAN: begin
                if (addr_q == LAST_ADDR) state_d = S_DRAIN;
                else                     addr_d  = addr_q + 1'b1;
            end
            S_DRAIN: begin
                state_d = S_COMMIT;
                commit  = 1'b1;
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // A new request always wins: restart from index 0 with an empty shadow set.
        if (line_start) begin
            state_d  = S_SCAN;
            addr_d   = '0;
            line_d   = next_line;
            commit   = 1'b0;
            count_d  = '0;
            sh_ovf_d = 1'b0;
            for (int i = 0; i < MAX_ACTIVE; i++) begin
                sh_type_d[i] = '0;
                sh_x_d[i]    = '0;
                sh_row_d[i]  = '0;
            end
`ifdef SPRITE_SCHED_DROPCNT_EN
            sh_drops_d = '0;
`endif
        end
    end

`ifdef SPRITE_SCHED_DROPCNT_EN
    assign drop_sum = {1'b0, drop_count_q} + {1'b0, sh_drops_d};
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            line_q       <= '0;
            eval_q       <= 1'b0;
            count_q      <= '0;
            sh_ovf_q     <= 1'b0;
            slot_valid_q <= '0;
            slot_type_q  <= '0;
            slot_x_q     <= '0;
            slot_row_q   <= '0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < MAX_ACTIVE; i++) begin
                sh_type_q[i] <= '0;
                sh_x_q[i]    <= '0;
                sh_row_q[i]  <= '0;
            end
`ifdef SPRITE_SCHED_DROPCNT_EN
            sh_drops_q   <= '0;
            drop_count_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            eval_q    <= eval_d;
            count_q   <= count_d;
            sh_ovf_q  <= sh_ovf_d;
            sh_type_q <= sh_type_d;
            sh_x_q    <= sh_x_d;
            sh_row_q  <= sh_row_d;
`ifdef SPRITE_SCHED_DROPCNT_EN
            sh_drops_q <= sh_drops_d;
`endif
            // Commit takes the shadow next-state so the final descriptor is included.
            if (commit) begin
                for (int i = 0; i < MAX_ACTIVE; i++) begin
                    slot_valid_q[i]          <= (CW'(i) < count_d);
                    slot_type_q[i*3 +: 3]    <= sh_type_d[i];
                    slot_x_q[i*X_W +: X_W]   <= sh_x_d[i];
                    slot_row_q[i*4 +: 4]     <= sh_row_d[i];
                end
                overflow_q <= sh_ovf_d;
`ifdef SPRITE_SCHED_DROPCNT_EN
                drop_count_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
`endif
            end
        end
    end

    assign desc_rd    = (state_q == S_SCAN);
    assign desc_addr  = desc_rd ? addr_q : '0;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_COMMIT);
    assign slot_valid = slot_valid_q;
    assign slot_type  = slot_type_q;
    assign slot_x     = slot_x_q;
    assign slot_row   = slot_row_q;
    assign overflow   = overflow_q;
`ifdef SPRITE_SCHED_DROPCNT_EN
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler: descriptor RAM model, reference hit model
// feeding an expected queue, compared at each done pulse.
module tb_sprite_line_scheduler;
    localparam int N    = 32;
    localparam int MAXA = 8;
    localparam int W    = 145;
    localparam int ROW_LSB  = 0;
    localparam int X_LSB    = 32;
    localparam int TYPE_LSB = 112;
    localparam int VAL_LSB  = 136;
    localparam int OVF_BIT  = 144;

    logic             Clk;
    logic             Reset;
    logic             line_start;
    logic [9:0]       next_line;
    logic             desc_rd;
    logic [4:0]       desc_addr;
    logic [23:0]      desc_data;
    logic [7:0]       slot_valid;
    logic [23:0]      slot_type;
    logic [79:0]      slot_x;
    logic [31:0]      slot_row;
    logic             busy;
    logic             done;
    logic             overflow;
`ifdef SPRITE_SCHED_DROPCNT_EN
    logic [7:0]       drop_count;
`endif

    sprite_line_scheduler dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .line_start (line_start),
        .next_line  (next_line),
        .desc_rd    (desc_rd),
        .desc_addr  (desc_addr),
        .desc_data  (desc_data),
        .slot_valid (slot_valid),
        .slot_type  (slot_type),
        .slot_x     (slot_x),
        .slot_row   (slot_row),
        .busy       (busy),
        .done       (done),
`ifdef SPRITE_SCHED_DROPCNT_EN
        .drop_count (drop_count),
`endif
        .overflow   (overflow)
    );

    // Clock / descriptor RAM model
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [23:0] mem [N];
    always @(posedge Clk) if (desc_rd) desc_data <= mem[desc_addr];

    // Scoreboard state
    logic [W-1:0] exp_q [$];
    int           drop_q [$];
    logic [W-1:0] cur_commit;
    int           exp_drops;
    int           n_checks;
    int           n_fail;
    int           heights [8] = '{16, 16, 14, 16, 9, 9, 9, 16};

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mk(input bit en, input int t, input int x, input int y);
        logic [23:0] d;
        d = {en, 3'(t), 10'(x), 10'(y)};
        return d;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < N; i++) mem[i] = '0;
    endtask

    task automatic push_expected(input int line);
        logic [W-1:0] e;
        int n;
        int drops;
        e = '0;
        n = 0;
        drops = 0;
        for (int i = 0; i < N; i++) begin
            int t;
            int x;
            int y;
            t = int'(mem[i][22:20]);
            x = int'(mem[i][19:10]);
            y = int'(mem[i][9:0]);
            if (mem[i][23] && line >= y && (line - y) < heights[t]) begin
                if (n < MAXA) begin
                    e[VAL_LSB + n] = 1'b1;
                    e[TYPE_LSB + 3*n +: 3] = 3'(t);
                    e[X_LSB + 10*n +: 10]  = 10'(x);
                    e[ROW_LSB + 4*n +: 4]  = 4'(line - y);
                    n++;
                end else begin
                    e[OVF_BIT] = 1'b1;
                    drops++;
                end
            end
        end
        exp_q.push_back(e);
        drop_q.push_back(drops);
    endtask

    task automatic compare_commit(input int cyc, input int exp_cyc);
        logic [W-1:0] e;
        int d;
        check("sb_depth", 160'(exp_q.size()), 160'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = drop_q.pop_front();
            check("done_latency", 160'(cyc), 160'(exp_cyc));
            check("slot_valid", 160'(slot_valid), 160'(e[VAL_LSB +: 8]));
            check("slot_type",  160'(slot_type),  160'(e[TYPE_LSB +: 24]));
            check("slot_x",     160'(slot_x),     160'(e[X_LSB +: 80]));
            check("slot_row",   160'(slot_row),   160'(e[ROW_LSB +: 32]));
            check("overflow",   160'(overflow),   160'(e[OVF_BIT]));
            exp_drops = (exp_drops + d > 255) ? 255 : exp_drops + d;
`ifdef SPRITE_SCHED_DROPCNT_EN
            check("drop_count", 160'(drop_count), 160'(exp_drops));
`endif
            cur_commit = e;
        end
    endtask

    // Drives one line_start, optionally a restart or a mid-scan reset, and tracks the scan.
    task automatic run_scan(input int line, input int restart_at, input int restart_line,
                            input int reset_at);
        int cyc;
        int limit;
        int exp_cyc;
        bit seen;
        if (reset_at < 0) push_expected(restart_at >= 0 ? restart_line : line);
        exp_cyc = (restart_at >= 0) ? restart_at + N + 2 : N + 2;
        limit   = (reset_at >= 0) ? reset_at + N + 10 : 200;
        cyc  = 0;
        seen = 1'b0;
        @(posedge Clk); #1;
        line_start = 1'b1;
        next_line  = 10'(line);
        while (!seen && cyc < limit) begin
            @(posedge Clk); #1;
            cyc++;
            line_start = 1'b0;
            if (cyc == 1) begin
                check("busy_start", 160'(busy), 160'(1));
                check("rd_start",   160'({desc_rd, desc_addr}), 160'({1'b1, 5'd0}));
            end
            if (cyc == 3)
                check("hold_during_scan", 160'({overflow, slot_valid, slot_type, slot_x, slot_row}),
                      160'(cur_commit));
            if (cyc == N && restart_at < 0 && reset_at < 0)
                check("rd_last", 160'({desc_rd, desc_addr}), 160'({1'b1, 5'(N-1)}));
            if (done) begin
                seen = 1'b1;
                if (reset_at < 0) compare_commit(cyc, exp_cyc);
            end
            if (reset_at >= 0 && cyc == reset_at + 1) begin
                check("rst_outputs", 160'({busy, done, desc_rd, desc_addr, overflow, slot_valid}), 160'(0));
                check("rst_slots", 160'({slot_type, slot_x, slot_row}), 160'(0));
`ifdef SPRITE_SCHED_DROPCNT_EN
                check("rst_drop_count", 160'(drop_count), 160'(0));
`endif
                Reset = 1'b0;
                cur_commit = '0;
                exp_drops = 0;
            end
            if (cyc == restart_at) begin
                line_start = 1'b1;
                next_line  = 10'(restart_line);
            end
            if (cyc == reset_at) Reset = 1'b1;
        end
        if (reset_at < 0) begin
            check("done_seen", 160'(seen), 160'(1));
            if (seen) begin
                @(posedge Clk); #1;
                check("idle_after_done", 160'({busy, done}), 160'(0));
            end
        end else begin
            check("done_absent", 160'(seen), 160'(0));
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_drops  = 0;
        cur_commit = '0;
        Reset      = 1'b1;
        line_start = 1'b0;
        next_line  = '0;
        desc_data  = '0;
        clear_mem();
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;

        check("reset_ctrl", 160'({busy, done, desc_rd, overflow}), 160'(0));
        check("reset_slots", 160'({slot_valid, slot_type, slot_x, slot_row}), 160'(0));

        // All disabled
        run_scan(20, -1, 0, -1);

        // Frog + bus
        mem[3] = mk(1, 0, 50, 10);
        mem[7] = mk(1, 2, 123, 15);
        run_scan(20, -1, 0, -1);

        // Long log boundary and y above line
        clear_mem();
        mem[0] = mk(1, 6, 7, 100);
        run_scan(108, -1, 0, -1);
        run_scan(109, -1, 0, -1);
        mem[0] = mk(1, 4, 7, 200);
        run_scan(5, -1, 0, -1);

        // Overflow: ten frogs
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = mk(1, 0, i * 10, 0);
        run_scan(3, -1, 0, -1);

        // Restart mid-scan
        clear_mem();
        mem[2] = mk(1, 7, 300, 30);
        mem[5] = mk(1, 0, 400, 10);
        run_scan(20, 5, 40, -1);

        // Reset mid-scan
        run_scan(20, -1, 0, 4);

        // Random tables
        for (int r = 0; r < 6; r++) begin
            int line;
            line = $urandom_range(20, 1000);
            for (int i = 0; i < N; i++)
                mem[i] = mk(1'($urandom_range(0, 1)), $urandom_range(0, 7),
                            $urandom_range(0, 1023), line - $urandom_range(0, 20));
            run_scan(line, -1, 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
